// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// Adds synchronous flush (bubble insertion) and a saturating back-pressure counter.
module pipe_stage_skid #(
    parameter int          DATA_W   = 96,
    parameter int          CTRL_W   = 3,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_inst,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_inst,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_waddr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] main_data, skid_data;
    logic [31:0]       main_inst, skid_inst;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid;

    // Entry validity is carried entirely by the state encoding.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    assign out_data  = main_data;
    assign out_inst  = main_inst;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_waddr = main_inst[11:7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= EMPTY;
        else      state <= state_next;
    end

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_next   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid  = 1'b1;
                        state_next = TWO;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        state_next     = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Flush turns the main entry into a NOP bubble but leaves the payload untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data <= '0;
            main_inst <= NOP_INST;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_inst <= NOP_INST;
            skid_ctrl <= '0;
        end else begin
            if (flush) begin
                main_inst <= NOP_INST;
                main_ctrl <= '0;
            end else if (load_main_in) begin
                main_data <= in_data;
                main_inst <= in_inst;
                main_ctrl <= in_ctrl;
            end else if (load_main_skid) begin
                main_data <= skid_data;
                main_inst <= skid_inst;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_inst <= in_inst;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register with a valid/ready handshake, replacing the fixed MEM/WB-style latch for every inter-stage boundary in the RV32I core. It carries a generic payload, the instruction word and the writeback control bits. A one-entry skid buffer gives full throughput under downstream back-pressure. It also adds synchronous flush (bubble insertion) and a saturating stall counter for performance monitoring.

Parameters:
DATA_W, 96, payload width (e.g. Addr + ALUResult + rdata, 3x32).
CTRL_W, 3, control width; bit 0 = reg_wr, bits [2:1] = wb_sel.
NOP_INST, 32'h0000_0013, instruction word loaded on reset and flush (addi x0,x0,0).
CNT_W, 16, stall counter width.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
flush  in  1  synchronous kill of all held entries, highest priority.
in_valid  in  1  upstream entry valid.
in_ready  out  1  stage can accept an entry this cycle.
in_data  in  DATA_W  upstream payload.
in_inst  in  32  upstream instruction word.
in_ctrl  in  CTRL_W  upstream control bits.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accepts the output entry.
out_data  out  DATA_W  output payload.
out_inst  out  32  output instruction word.
out_ctrl  out  CTRL_W  output control; forced to 0 when out_valid=0.
out_waddr  out  5  destination register, out_inst[11:7] (combinational).
stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. Each entry holds {data, inst, ctrl, valid}.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = ~skid_valid. It is a pure function of registered state, with no combinational path from out_ready.
- State encoding: EMPTY (main invalid), ONE (main valid, skid empty), TWO (both valid).
- EMPTY: if in_fire, main loads the input and the state goes to ONE; otherwise stay.
- ONE, in_fire & out_fire: main loads the input; stay in ONE.
- ONE, in_fire & ~out_fire: skid loads the input; go to TWO.
- ONE, ~in_fire & out_fire: go to EMPTY.
- ONE, neither fire: hold.
- TWO: in_ready=0. If out_fire, main loads from skid and the state goes to ONE; otherwise hold.
- Latency: 1 cycle input to output when not stalled. Throughput: 1 entry/cycle.
- Ordering: strict FIFO. The skid entry is never overtaken.
- Flush (sync), overriding all of the above:
  - both valids cleared; state goes to EMPTY.
  - a simultaneous in_fire is discarded.
  - main inst loads NOP_INST; main ctrl loads 0; data is held.
  - in_ready=1 in the following cycle.
- Reset (async, rst=0):
  - state EMPTY; out_valid=0; in_ready=1.
  - out_data=0, out_inst=NOP_INST, out_ctrl=0, out_waddr=0, stall_cnt=0.
  - no X reset values anywhere.
  - reset asserted mid-transfer drops both entries immediately, without waiting for a clock edge.
- stall_cnt:
  - +1 on each cycle with out_valid & ~out_ready, including during TWO.
  - saturates at 2^CNT_W-1.
  - cleared only by reset; unaffected by flush.
- Payload is copied bit-exact; no width conversion. The entry updates only on the load conditions above; otherwise all registers hold.

Test Plan:
1. Reset then stream: rst low then high; drive in_valid=1 with inst 0x00A00093, 0x00100113, 0x00200193, out_ready=1 -> out_valid rises 1 cycle later; outputs match inputs in order; out_waddr = 1, 2, 3; in_ready stays 1.
2. Back-pressure/skid: out_ready=0 while sending A, B -> A held on the outputs, B in skid, in_ready=0, C held upstream; raise out_ready -> A, B, C delivered in order with no loss or duplication.
3. Flush in TWO with in_valid=1: flush pulse -> next cycle out_valid=0, out_inst=0x00000013, out_ctrl=0, in_ready=1; the discarded input is never emitted.
4. Async reset mid-stall: in TWO with stall_cnt=5, drive rst=0 between edges -> out_valid=0, stall_cnt=0 immediately, out_inst=0x00000013.
5. Counter saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; a subsequent flush leaves it at 15.
6. Randomised valid/ready with a scoreboard, 10k entries, DATA_W=96 -> 0 mismatches; in_ready never depends on same-cycle out_ready.
